csa_pipe_adder: RTL and testbench
=================================

Name: csa_pipe_adder

Overview:
- Parametrised, pipelined successor to the 8-bit combinational carry-select adder.
- Splits a WIDTH-bit add into NBLK = WIDTH/BLOCK carry-select blocks, one block per pipeline stage.
- Each stage precomputes its block sum for carry-in 0 and carry-in 1, then selects with the carry registered by the previous stage.
- Sits in the datapath between valid/ready producers and consumers.
- Sustains one add per clock and stalls cleanly under backpressure.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be a multiple of BLOCK.
- BLOCK, 8, bits per carry-select block, which is also bits per stage. Must be at least 1.
- NBLK, WIDTH/BLOCK, derived stage count and latency. Not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a, b, cin are valid
- in_ready  out  1  adder accepts operands this cycle
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- cin  in  1  carry into bit 0
- out_valid  out  1  s and c are valid
- out_ready  in  1  consumer accepts the result
- s  out  WIDTH  sum a+b+cin, modulo 2^WIDTH
- c  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow; present only with CSA_OVF_EN

Behaviour:
- Clock and reset: one clock domain on clk. rst is asynchronous and active-high.
- Reset values: every stage valid bit = 0, out_valid = 0, s = 0, c = 0, ovf = 0. in_ready = 1 once rst deasserts.
- Reset asserted mid-operation discards all in-flight results. No partial result ever emerges.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - When adv = 1, every stage register loads from its predecessor.
  - When adv = 0, every stage register holds and in-flight data is not lost.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Stage 0 (on accept):
  - Registers block 0 sum: a[BLOCK-1:0] + b[BLOCK-1:0] + cin.
  - Registers block-0 carry.
  - Registers the upper operand bits unchanged.
  - Its valid bit = in_valid.
- Stage k, for k = 1..NBLK-1:
  - Computes sum0/carry0 and sum1/carry1 of block k from the delayed operands.
  - Selects by the stage k-1 carry register.
  - Appends the selected block to the accumulated lower sum bits.
  - Propagates the selected carry.
- Output: the final stage drives s, c and out_valid directly from registers. No combinational path from a, b or cin to the outputs.
- Latency and throughput:
  - NBLK cycles from input transfer to out_valid when unstalled. With defaults, accept at edge N gives out_valid after edge N+3 (4 stages).
  - One result per cycle at full throughput. Bubbles travel as valid = 0 slots and are not collapsed.
- Data integrity:
  - Data registers may load when their valid bit = 0, but s and c must be ignored while out_valid = 0.
  - A bench checks s and c only when out_valid = 1.
  - Ordering is strictly FIFO.
- Arithmetic: unsigned modulo 2^WIDTH, with the carry-out on c. Wrap-around, for example all-ones + 1, gives s = 0 and c = 1.
- Degenerate cases:
  - NBLK = 1: single stage, latency 1.
  - BLOCK = WIDTH: same as NBLK = 1.
- Simultaneous output and input transfer in the same cycle is legal and is the steady state.

Optional Feature:
- Macro: CSA_OVF_EN
- Defined:
  - Adds output port ovf.
  - ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), i.e. two's-complement overflow.
  - Operand sign bits are carried down the pipeline, so ovf is aligned with s and c.
  - ovf resets to 0.
- Not defined: no ovf port and no sign-bit pipeline registers. All other behaviour is identical.

Test Plan (defaults WIDTH=32, BLOCK=8, NBLK=4):
- Reset then a single add: a=0x00000003, b=0, cin=0 -> out_valid 4 cycles after accept; s=0x00000003, c=0.
- Cross-block carry chain: a=0x00FFFFFF, b=0x00000001, cin=0 -> s=0x01000000, c=0. Then a=0xFFFFFFFF, b=0, cin=1 -> s=0x00000000, c=1.
- Back-to-back stream with out_ready=1: the six pairs (3,0), (0,1), (6,2), (8,3), (12,3), (8,4) on consecutive cycles -> results 3, 1, 8, 11, 15, 12 on consecutive cycles, in order, with in_ready stuck at 1.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, s and c stable, no loss. After release, the remaining results drain in order, one per cycle.
- Reset mid-flight: assert rst with 3 adds in flight -> out_valid=0 immediately (asynchronous). After release, no stale result appears.
- With CSA_OVF_EN: a=0x7FFFFFFF, b=1 -> s=0x80000000, c=0, ovf=1. Then a=0x80000000, b=0x80000000 -> s=0, c=1, ovf=1.

Source files
------------

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder: one BLOCK-bit carry-select block per stage, valid/ready handshake.
// Optional signed-overflow output when CSA_OVF_EN is defined.
module csa_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c
`ifdef CSA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NBLK = WIDTH / BLOCK;

   function automatic logic [BLOCK:0] blk_add(input logic [BLOCK-1:0] x,
                                              input logic [BLOCK-1:0] y,
                                              input logic             ci);
      return {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, ci};
   endfunction

   // Both carry-in outcomes are formed up front; the incoming carry only drives the mux.
   function automatic logic [BLOCK:0] csel(input logic [BLOCK-1:0] x,
                                           input logic [BLOCK-1:0] y,
                                           input logic             sel);
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      r0 = blk_add(x, y, 1'b0);
      r1 = blk_add(x, y, 1'b1);
      return sel ? r1 : r0;
   endfunction

   logic             vld_p [NBLK];
   logic [WIDTH-1:0] sum_p [NBLK];
   logic             cy_p  [NBLK];
   logic [WIDTH-1:0] a_p   [NBLK];
   logic [WIDTH-1:0] b_p   [NBLK];

   logic [BLOCK:0]   blk_r    [NBLK];
   logic [WIDTH-1:0] nxt_sum  [NBLK];
   logic             adv;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      for (int k = 0; k < NBLK; k++) begin
         blk_r[k]   = '0;
         nxt_sum[k] = '0;
      end
      blk_r[0]   = blk_add(a[BLOCK-1:0], b[BLOCK-1:0], cin);
      nxt_sum[0] = WIDTH'(blk_r[0][BLOCK-1:0]);
      for (int k = 1; k < NBLK; k++) begin
         blk_r[k]   = csel(a_p[k-1][k*BLOCK +: BLOCK], b_p[k-1][k*BLOCK +: BLOCK], cy_p[k-1]);
         nxt_sum[k] = sum_p[k-1];
         nxt_sum[k][k*BLOCK +: BLOCK] = blk_r[k][BLOCK-1:0];
      end
   end

   // Stage boundary: every stage shifts together on adv, or the whole pipe holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NBLK; k++) begin
            vld_p[k] <= 1'b0;
            sum_p[k] <= '0;
            cy_p[k]  <= 1'b0;
            a_p[k]   <= '0;
            b_p[k]   <= '0;
         end
      end else if (adv) begin
         vld_p[0] <= in_valid;
         a_p[0]   <= a;
         b_p[0]   <= b;
         for (int k = 0; k < NBLK; k++) begin
            sum_p[k] <= nxt_sum[k];
            cy_p[k]  <= blk_r[k][BLOCK];
         end
         for (int k = 1; k < NBLK; k++) begin
            vld_p[k] <= vld_p[k-1];
            a_p[k]   <= a_p[k-1];
            b_p[k]   <= b_p[k-1];
         end
      end
   end

   assign out_valid = vld_p[NBLK-1];
   assign s         = sum_p[NBLK-1];
   assign c         = cy_p[NBLK-1];

`ifdef CSA_OVF_EN
   // Operand signs ride along in the last stage's operand copy, so ovf lines up with s.
   assign ovf = (a_p[NBLK-1][WIDTH-1] == b_p[NBLK-1][WIDTH-1]) &&
                (sum_p[NBLK-1][WIDTH-1] != a_p[NBLK-1][WIDTH-1]);
`endif

   logic unused_tail;
   assign unused_tail = ^{a_p[NBLK-1], b_p[NBLK-1]};

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder at default parameters (WIDTH=32, BLOCK=8).
module tb_csa_pipe_adder;

   localparam int W    = 32;
   localparam int NBLK = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         c;
`ifdef CSA_OVF_EN
   logic         ovf;
`endif

   csa_pipe_adder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .c         (c)
`ifdef CSA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb [$];
   int   tq [$];
   int   cyc;
   int   errors;
   int   checks;
   logic done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0] t;
      exp_t       r;
      t   = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      r.s = t[W-1:0];
      r.c = t[W];
      r.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Outputs and accepts are both observed mid-cycle, ahead of the edge that transfers them.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            exp_t e;
            tq.push_back(cyc);
            if (sb.size() == 0) begin
               chk("stale_result", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sum", s, e.s);
               chk("carry", c, e.c);
`ifdef CSA_OVF_EN
               chk("ovf", ovf, e.v);
`endif
            end
         end
         if (in_valid && in_ready) sb.push_back(model(a, b, cin));
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int   n;
      logic acc;
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", 64'(n < 60), 1);
   endtask

   task automatic chk_run(input string tag, input int cnt);
      chk({tag, "_count"}, tq.size(), cnt);
      for (int i = 1; i < tq.size(); i++) chk({tag, "_gap"}, tq[i] - tq[i-1], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic [W-1:0] s_hold;
      logic         c_hold;
      errors = 0;
      checks = 0;
      cyc = 0;
      done = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_s", s, 0);
      chk("rst_c", c, 0);
`ifdef CSA_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // Single add and its latency
      send(32'h3, 32'h0, 1'b0);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("t1_latency", lat, NBLK - 1);
      chk("t1_sum", s, 32'h3);
      chk("t1_carry", c, 0);
      drain();

      // Carry across block boundaries and full wrap-around
      send(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      drain();

      // Back-to-back stream at full throughput
      tq.delete();
      begin
         logic [W-1:0] sa [6] = '{32'd3, 32'd0, 32'd6, 32'd8, 32'd12, 32'd8};
         logic [W-1:0] sbv [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3, 32'd4};
         for (int i = 0; i < 6; i++) begin
            send(sa[i], sbv[i], 1'b0);
            chk("stream_in_ready", in_ready, 1);
         end
      end
      drain();
      chk_run("stream", 6);

      // Backpressure with a full pipe
      out_ready = 1'b0;
      send(32'h0000_0100, 32'h0000_0023, 1'b0);
      send(32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
      send(32'h1234_5678, 32'h8765_4321, 1'b0);
      send(32'h8000_0000, 32'h8000_0000, 1'b1);
      a = 32'd7;
      b = 32'd7;
      cin = 1'b0;
      in_valid = 1'b1;
      chk("bp_out_valid", out_valid, 1);
      s_hold = s;
      c_hold = c;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_s_stable", s, s_hold);
         chk("bp_c_stable", c, c_hold);
         chk("bp_valid_held", out_valid, 1);
      end
      chk("bp_no_loss", sb.size(), 4);
      tq.delete();
      out_ready = 1'b1;
      send(32'd7, 32'd7, 1'b0);
      drain();
      chk_run("bp_release", 5);

      // Reset with three adds in flight
      send(32'h11, 32'h22, 1'b0);
      send(32'h33, 32'h44, 1'b0);
      send(32'h55, 32'h66, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_s", s, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      idle(10);
      chk("post_rst_no_stale", out_valid, 0);
      send(32'h5, 32'h6, 1'b0);
      drain();

`ifdef CSA_OVF_EN
      // Signed overflow
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      send(32'h8000_0000, 32'h8000_0000, 1'b0);
      drain();
`endif

      // Random traffic under random backpressure
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               else send($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
